videosync_gen: RTL and testbench
================================

# videosync_gen

Parametrised video timing generator for the LSPC video path: successor to the fixed NTSC/PAL sync block. Counts pixels and raster lines from a pixel-rate enable on the 24 MHz clock. Decodes HSYNC, VSYNC, horizontal and vertical blanking, line/frame strobes and the line-parity FLIP bit from parameterised thresholds. Mode changes are applied only at frame boundaries, which the fixed block does not do. Drives sprite/fix fetch sequencing and the video DAC sync pins.

## Interface
- PIX_W, 9, pixel counter width
- RAS_W, 9, raster counter width
- H_TOTAL, 384, pixel clocks per line
- H_ACT, 320, active pixels per line (pixels 0..H_ACT-1)
- H_SYNC_START, 336, first pixel of HSYNC
- H_SYNC_LEN, 32, HSYNC width in pixels
- V_ACT, 224, active lines per frame (lines 0..V_ACT-1)
- V_TOTAL_N / V_TOTAL_P, 264 / 312, lines per frame, NTSC / PAL
- V_SYNC_N / V_SYNC_P, 240 / 264, first VSYNC line, NTSC / PAL
- V_SYNC_LEN, 8, VSYNC width in lines

Ports:
- CLK_24MB  in  1  system clock; all logic on rising edge
- nRESETP  in  1  reset; synchronous, active-low
- PIX_EN  in  1  pixel-rate enable (one CLK_24MB cycle per pixel)
- VMODE  in  1  0 = NTSC, 1 = PAL
- PIXELC  out  PIX_W  current pixel count
- RASTERC  out  RAS_W  current line count
- HSYNC  out  1  horizontal sync, active-low
- VSYNC  out  1  vertical sync, active-low
- BNK  out  1  0 during vertical blank, 1 on active lines
- BNKB  out  1  ~BNK
- CHBL  out  1  1 during horizontal blank
- FLIP  out  1  line parity; toggles every line
- LINE_START  out  1  one-cycle strobe, first pixel of each line
- FRAME_START  out  1  one-cycle strobe, first pixel of each frame
- CSYNC  out  1  composite sync, active-low (see Configuration)

## Operation
- Reset (nRESETP=0 at an edge):
  - PIXELC=0, RASTERC=0, FLIP=0.
  - Mode latch loads VMODE.
  - HSYNC=1, VSYNC=1, BNK=0, BNKB=1, CHBL=1, LINE_START=0, FRAME_START=0, CSYNC=1.
- Pixel counter: on PIX_EN, increments. At H_TOTAL-1 it wraps to 0 and FLIP toggles.
- Raster counter: advances only when the pixel counter wraps. At V_TOTAL-1 it wraps to 0.
  - V_TOTAL and V_SYNC come from the mode latch: V_TOTAL_N/V_SYNC_N if latch=0, V_TOTAL_P/V_SYNC_P if latch=1.
- Mode latch samples VMODE only on the raster wrap edge. VMODE changes mid-frame have no effect until the next frame.
- Decodes use half-open ranges on the current counters:
  - CHBL=1 when PIXELC ≥ H_ACT.
  - HSYNC=0 when H_SYNC_START ≤ PIXELC < H_SYNC_START+H_SYNC_LEN.
  - BNK=0 when RASTERC ≥ V_ACT.
  - VSYNC=0 when V_SYNC ≤ RASTERC < V_SYNC+V_SYNC_LEN.
- LINE_START=1 while PIXELC=0; FRAME_START=1 while PIXELC=0 and RASTERC=0. Each is asserted for the single cycle following the enable that produced the count.
- PIX_EN=0: counters, FLIP, mode latch and all decoded outputs hold. Strobes drop to 0 after one cycle regardless of PIX_EN.
- PIX_EN held at 1 constantly: the block advances one pixel per clock; this is legal.
- Elaboration check fails (generate-time error) unless:
  - H_TOTAL ≤ 2^PIX_W and V_TOTAL_P, V_TOTAL_N ≤ 2^RAS_W.
  - H_SYNC_START+H_SYNC_LEN ≤ H_TOTAL.
  - V_SYNC_x+V_SYNC_LEN ≤ V_TOTAL_x.

## Timing
- Counters update on the PIX_EN edge.
- Decoded outputs (HSYNC, VSYNC, BNK, BNKB, CHBL, CSYNC) are registered from the next-count values, so they change on the same edge as the counters. Zero lag relative to PIXELC/RASTERC.
- Strobes are registered the same way and high for exactly one CLK_24MB cycle.
- First edge with nRESETP=1 and PIX_EN=1: PIXELC becomes 1, outputs reflect pixel 1.
- Mid-frame reset: all state returns to reset values on that edge, with no partial-line completion.

## Configuration
- VIDEOSYNC_CSYNC_EN defined: CSYNC is registered as ~(HSYNC_next ^ VSYNC_next), i.e. XNOR, aligned with HSYNC/VSYNC. HSYNC pulses appear inverted during VSYNC.
- VIDEOSYNC_CSYNC_EN not defined: CSYNC is tied to 1 and no CSYNC logic is generated.

## Test plan
- Reset with PIX_EN every 4th clock, VMODE=0 -> LINE_START period 1536 clocks; FRAME_START period 264×1536 = 405504 clocks; FLIP toggles at every LINE_START.
- Default parameters -> HSYNC low for pixels 336..367 (32 pixels), CHBL high for pixels 320..383, BNK low for lines 224..263, VSYNC low for lines 240..247.
- VMODE 0→1 asserted at line 100 -> current frame still wraps after line 263; next frame runs 312 lines with VSYNC on lines 264..271.
- PIX_EN held low for 1000 clocks at pixel 200 -> PIXELC, RASTERC and outputs hold; no strobes; counting resumes at pixel 201.
- nRESETP pulsed low at line 150, pixel 50 -> next cycle PIXELC=0, RASTERC=0, FLIP=0, HSYNC=1, VSYNC=1, BNK=0, CHBL=1.
- With VIDEOSYNC_CSYNC_EN -> CSYNC equals XNOR of HSYNC/VSYNC every cycle. Without the macro -> CSYNC constant 1.

Source files
------------

// File: rtl/videosync_gen.sv
// Video timing generator: pixel/raster counters with NTSC/PAL line counts switched only at frame wrap.
// Define VIDEOSYNC_CSYNC_EN to generate the registered composite sync output on CSYNC.
module videosync_gen #(
  parameter int PIX_W        = 9,
  parameter int RAS_W        = 9,
  parameter int H_TOTAL      = 384,
  parameter int H_ACT        = 320,
  parameter int H_SYNC_START = 336,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_ACT        = 224,
  parameter int V_TOTAL_N    = 264,
  parameter int V_TOTAL_P    = 312,
  parameter int V_SYNC_N     = 240,
  parameter int V_SYNC_P     = 264,
  parameter int V_SYNC_LEN   = 8
) (
  input  logic             CLK_24MB,
  input  logic             nRESETP,
  input  logic             PIX_EN,
  input  logic             VMODE,
  output logic [PIX_W-1:0] PIXELC,
  output logic [RAS_W-1:0] RASTERC,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             BNK,
  output logic             BNKB,
  output logic             CHBL,
  output logic             FLIP,
  output logic             LINE_START,
  output logic             FRAME_START,
  output logic             CSYNC
);

  if ((H_TOTAL > (32'd1 << PIX_W)) || (V_TOTAL_N > (32'd1 << RAS_W)) ||
      (V_TOTAL_P > (32'd1 << RAS_W)) || (H_SYNC_START + H_SYNC_LEN > H_TOTAL) ||
      (V_SYNC_N + V_SYNC_LEN > V_TOTAL_N) || (V_SYNC_P + V_SYNC_LEN > V_TOTAL_P)) begin : g_param_err
    $error("videosync_gen: timing parameters out of range");
  end

  localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
  localparam logic [RAS_W-1:0] RAS_ZERO = {RAS_W{1'b0}};
  localparam logic [RAS_W-1:0] RAS_ONE  = RAS_W'(1);
  localparam logic [PIX_W-1:0] H_LAST   = PIX_W'(H_TOTAL - 1);
  localparam logic [RAS_W-1:0] V_LAST_N = RAS_W'(V_TOTAL_N - 1);
  localparam logic [RAS_W-1:0] V_LAST_P = RAS_W'(V_TOTAL_P - 1);
  // Range bounds carry one extra bit so an end bound equal to 2^W still compares correctly
  localparam logic [PIX_W:0]   H_ACT_X  = (PIX_W+1)'(H_ACT);
  localparam logic [PIX_W:0]   HS_BEG   = (PIX_W+1)'(H_SYNC_START);
  localparam logic [PIX_W:0]   HS_END   = (PIX_W+1)'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [RAS_W:0]   V_ACT_X  = (RAS_W+1)'(V_ACT);
  localparam logic [RAS_W:0]   VS_BEG_N = (RAS_W+1)'(V_SYNC_N);
  localparam logic [RAS_W:0]   VS_END_N = (RAS_W+1)'(V_SYNC_N + V_SYNC_LEN);
  localparam logic [RAS_W:0]   VS_BEG_P = (RAS_W+1)'(V_SYNC_P);
  localparam logic [RAS_W:0]   VS_END_P = (RAS_W+1)'(V_SYNC_P + V_SYNC_LEN);

  logic [PIX_W-1:0] pixelc_r, pix_next_s;
  logic [RAS_W-1:0] rasterc_r, ras_next_s, v_last_s;
  logic             flip_r, flip_next_s, mode_r, mode_next_s;
  logic             hsync_r, vsync_r, bnk_r, bnkb_r, chbl_r, line_start_r, frame_start_r;
  logic [PIX_W:0]   pix_x_s;
  logic [RAS_W:0]   ras_x_s, vs_beg_s, vs_end_s;
  logic             hsync_next_s, vsync_next_s, bnk_next_s, chbl_next_s;

  assign v_last_s = mode_r ? V_LAST_P : V_LAST_N;

  // Next pixel/raster count, line parity and frame-aligned mode latch
  always_comb begin
    pix_next_s  = pixelc_r;
    ras_next_s  = rasterc_r;
    flip_next_s = flip_r;
    mode_next_s = mode_r;
    if (PIX_EN) begin
      if (pixelc_r == H_LAST) begin
        pix_next_s  = PIX_ZERO;
        flip_next_s = ~flip_r;
        if (rasterc_r == v_last_s) begin
          ras_next_s  = RAS_ZERO;
          mode_next_s = VMODE;
        end else begin
          ras_next_s = rasterc_r + RAS_ONE;
        end
      end else begin
        pix_next_s = pixelc_r + PIX_ONE;
      end
    end else begin
      pix_next_s = pixelc_r;
    end
  end

  // Decode of the next counts so registered outputs line up with the counters
  always_comb begin
    pix_x_s = {1'b0, pix_next_s};
    ras_x_s = {1'b0, ras_next_s};
    if (mode_next_s) begin
      vs_beg_s = VS_BEG_P;
      vs_end_s = VS_END_P;
    end else begin
      vs_beg_s = VS_BEG_N;
      vs_end_s = VS_END_N;
    end
    chbl_next_s  = (pix_x_s >= H_ACT_X);
    hsync_next_s = ~((pix_x_s >= HS_BEG) && (pix_x_s < HS_END));
    bnk_next_s   = (ras_x_s < V_ACT_X);
    vsync_next_s = ~((ras_x_s >= vs_beg_s) && (ras_x_s < vs_end_s));
  end

  // Counters, mode latch, decoded outputs and strobes
  always_ff @(posedge CLK_24MB) begin
    if (!nRESETP) begin
      pixelc_r      <= PIX_ZERO;
      rasterc_r     <= RAS_ZERO;
      flip_r        <= 1'b0;
      mode_r        <= VMODE;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      bnk_r         <= 1'b0;
      bnkb_r        <= 1'b1;
      chbl_r        <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      pixelc_r      <= pix_next_s;
      rasterc_r     <= ras_next_s;
      flip_r        <= flip_next_s;
      mode_r        <= mode_next_s;
      line_start_r  <= PIX_EN && (pix_next_s == PIX_ZERO);
      frame_start_r <= PIX_EN && (pix_next_s == PIX_ZERO) && (ras_next_s == RAS_ZERO);
      if (PIX_EN) begin
        hsync_r <= hsync_next_s;
        vsync_r <= vsync_next_s;
        bnk_r   <= bnk_next_s;
        bnkb_r  <= ~bnk_next_s;
        chbl_r  <= chbl_next_s;
      end
    end
  end

`ifdef VIDEOSYNC_CSYNC_EN
  logic csync_r;

  // Composite sync: XNOR keeps HSYNC polarity outside VSYNC and inverts it inside
  always_ff @(posedge CLK_24MB) begin
    if (!nRESETP) begin
      csync_r <= 1'b1;
    end else if (PIX_EN) begin
      csync_r <= ~(hsync_next_s ^ vsync_next_s);
    end
  end

  assign CSYNC = csync_r;
`else
  assign CSYNC = 1'b1;
`endif

  assign PIXELC      = pixelc_r;
  assign RASTERC     = rasterc_r;
  assign FLIP        = flip_r;
  assign HSYNC       = hsync_r;
  assign VSYNC       = vsync_r;
  assign BNK         = bnk_r;
  assign BNKB        = bnkb_r;
  assign CHBL        = chbl_r;
  assign LINE_START  = line_start_r;
  assign FRAME_START = frame_start_r;

endmodule

// File: tb/tb_videosync_gen.sv
// Directed bench for videosync_gen: default horizontal timing, vertical timing shrunk to short frames.
module tb_videosync_gen;
  localparam int VA     = 6;
  localparam int VT_N   = 10;
  localparam int VT_P   = 12;
  localparam int VS_N   = 7;
  localparam int VS_P   = 9;
  localparam int VS_LEN = 2;

  logic       clk_24mb = 1'b0;
  logic       nresetp, pix_en, vmode;
  logic [8:0] pixelc, rasterc;
  logic       hsync, vsync, bnk, bnkb, chbl, flip, line_start, frame_start, csync;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state: counters per the timing description, expected registered outputs
  int   m_pix, m_ras;
  logic m_flip, m_mode;
  logic e_hs, e_vs, e_bnk, e_chbl, e_ls, e_fs, e_cs;

  int   ls_last = -1, ls_gap = 0, ls_count = 0;
  int   fs_last = -1, fs_gap = 0, fs_seen = 0;
  int   vs_line = -1;
  logic vs_prev = 1'b1;

  videosync_gen #(
    .V_ACT(VA), .V_TOTAL_N(VT_N), .V_TOTAL_P(VT_P),
    .V_SYNC_N(VS_N), .V_SYNC_P(VS_P), .V_SYNC_LEN(VS_LEN)
  ) dut (
    .CLK_24MB(clk_24mb), .nRESETP(nresetp), .PIX_EN(pix_en), .VMODE(vmode),
    .PIXELC(pixelc), .RASTERC(rasterc), .HSYNC(hsync), .VSYNC(vsync),
    .BNK(bnk), .BNKB(bnkb), .CHBL(chbl), .FLIP(flip),
    .LINE_START(line_start), .FRAME_START(frame_start), .CSYNC(csync)
  );

  always #20 clk_24mb = ~clk_24mb;

  always @(posedge clk_24mb) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("PIXELC", pixelc, m_pix);
    check_eq("RASTERC", rasterc, m_ras);
    check_eq("FLIP", flip, m_flip);
    check_eq("HSYNC", hsync, e_hs);
    check_eq("VSYNC", vsync, e_vs);
    check_eq("BNK", bnk, e_bnk);
    check_eq("BNKB", bnkb, !e_bnk);
    check_eq("CHBL", chbl, e_chbl);
    check_eq("LINE_START", line_start, e_ls);
    check_eq("FRAME_START", frame_start, e_fs);
    check_eq("CSYNC", csync, e_cs);
  endtask

  task automatic model_step(input logic en);
    int vtot;
    int vs0;
    if (en) begin
      vtot = m_mode ? VT_P : VT_N;
      if (m_pix == 383) begin
        m_pix  = 0;
        m_flip = ~m_flip;
        if (m_ras == vtot - 1) begin
          m_ras  = 0;
          m_mode = vmode;
        end else begin
          m_ras = m_ras + 1;
        end
      end else begin
        m_pix = m_pix + 1;
      end
      vs0    = m_mode ? VS_P : VS_N;
      e_chbl = (m_pix >= 320);
      e_hs   = !((m_pix >= 336) && (m_pix < 368));
      e_bnk  = (m_ras < VA);
      e_vs   = !((m_ras >= vs0) && (m_ras < vs0 + VS_LEN));
      e_ls   = (m_pix == 0);
      e_fs   = (m_pix == 0) && (m_ras == 0);
`ifdef VIDEOSYNC_CSYNC_EN
      e_cs   = !(e_hs ^ e_vs);
`else
      e_cs   = 1'b1;
`endif
    end else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
  endtask

  task automatic track();
    if (line_start) begin
      if (ls_last >= 0) ls_gap = cyc - ls_last;
      ls_last = cyc;
      ls_count++;
    end
    if (frame_start) begin
      if (fs_last >= 0) fs_gap = cyc - fs_last;
      fs_last = cyc;
      fs_seen++;
    end
    if (vs_prev && !vsync) vs_line = rasterc;
    vs_prev = vsync;
  endtask

  task automatic pix_tick(input logic en);
    pix_en = en;
    @(posedge clk_24mb);
    #1;
    model_step(en);
    check_all();
    track();
  endtask

  task automatic do_reset(input logic en);
    nresetp = 1'b0;
    pix_en  = en;
    @(posedge clk_24mb);
    #1;
    m_pix = 0; m_ras = 0; m_flip = 1'b0; m_mode = vmode;
    e_hs = 1'b1; e_vs = 1'b1; e_bnk = 1'b0; e_chbl = 1'b1;
    e_ls = 1'b0; e_fs = 1'b0; e_cs = 1'b1;
    check_all();
    track();
    nresetp = 1'b1;
  endtask

  task automatic run_to(input int r, input int p, input int limit);
    int n = 0;
    do begin
      pix_tick(1'b1);
      n++;
    end while (!((m_ras == r) && (m_pix == p)) && (n < limit));
  endtask

  initial begin
    nresetp = 1'b1;
    pix_en  = 1'b0;
    vmode   = 1'b0;
    do_reset(1'b0);
    do_reset(1'b0);

    // Outputs hold their reset values while PIX_EN stays low
    for (int i = 0; i < 3; i++) pix_tick(1'b0);
    check_eq("hold_rst_bnk", bnk, 0);
    check_eq("hold_rst_chbl", chbl, 1);

    // One pixel every 4th clock: 1536-clock lines, FLIP alternating at each line start
    for (int i = 0; i < 4608; i++) begin
      pix_tick((i % 4) == 0);
      if (i == 0) begin
        check_eq("first_pix", pixelc, 1);
        check_eq("first_chbl", chbl, 0);
        check_eq("first_bnk", bnk, 1);
      end
      if (line_start && (ls_count >= 2)) check_eq("ls_period", ls_gap, 1536);
      if (line_start) check_eq("flip_at_ls", flip, ls_count % 2);
    end
    check_eq("ls_count", ls_count, 3);

    // Enable held low mid-line: everything freezes, then resumes at the next pixel
    run_to(4, 200, 2000);
    for (int i = 0; i < 1000; i++) pix_tick(1'b0);
    check_eq("hold_pix", pixelc, 200);
    check_eq("hold_ras", rasterc, 4);
    pix_tick(1'b1);
    check_eq("resume_pix", pixelc, 201);

    // Mode switch mid-frame takes effect only on the following frame
    fs_seen = 0;
    run_to(0, 0, 5000);
    check_eq("fs_first", fs_seen, 1);
    run_to(3, 0, 2000);
    vmode = 1'b1;
    run_to(0, 0, 4000);
    check_eq("fs_gap_ntsc", fs_gap, 3840);
    check_eq("vs_line_ntsc", vs_line, 7);
    run_to(0, 0, 5000);
    check_eq("fs_gap_pal", fs_gap, 4608);
    check_eq("vs_line_pal", vs_line, 9);

    // Mid-frame reset reloads the mode latch from VMODE
    run_to(2, 0, 1000);
    vmode = 1'b0;
    run_to(5, 50, 2000);
    do_reset(1'b1);
    check_eq("rst_pix", pixelc, 0);
    check_eq("rst_ras", rasterc, 0);
    check_eq("rst_chbl", chbl, 1);
    run_to(8, 0, 4000);
    check_eq("vs_line_rst", vs_line, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
